// File: rtl/btn_pulse.sv
// Push-button debouncer producing clean one-cycle press, release and
// long-press strobes plus a debounced pressed level.
module btn_pulse #(
    parameter int unsigned DEBOUNCE_TIME  = 250000,
    parameter int unsigned LONG_TIME      = 12000000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic trig,
    output logic rel,
    output logic long_press,
    output logic held
);

    localparam logic        INACTIVE  = BTN_ACTIVE_LOW;
    localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_TIME - 1);
    localparam logic [23:0] LONG_LAST = 24'(LONG_TIME - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    logic        s1, s2;
    logic        act;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] lcnt_q, lcnt_d;
    logic        long_done_q, long_done_d;
    logic        trig_d, rel_d, long_d, held_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= INACTIVE;
            s2 <= INACTIVE;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    assign act = s2 ^ INACTIVE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lcnt_q      <= '0;
            long_done_q <= 1'b0;
            trig        <= 1'b0;
            rel         <= 1'b0;
            long_press  <= 1'b0;
            held        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcnt_q      <= lcnt_d;
            long_done_q <= long_done_d;
            trig        <= trig_d;
            rel         <= rel_d;
            long_press  <= long_d;
            held        <= held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lcnt_d      = lcnt_q;
        long_done_d = long_done_q;
        trig_d      = 1'b0;
        rel_d       = 1'b0;
        long_d      = 1'b0;
        held_d      = held;

        unique case (state_q)
            IDLE: begin
                if (act) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!act) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    trig_d      = 1'b1;
                    held_d      = 1'b1;
                    lcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            HELD: begin
                if (!act) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (act) begin
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    held_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A confirmed release in the same cycle as the long-press match wins.
        if ((state_q == HELD || state_q == REL_CHK) && !long_done_q && !rel_d) begin
            if (lcnt_q == LONG_LAST) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end else begin
                lcnt_d = lcnt_q + 24'd1;
            end
        end
    end

endmodule
